// File: rtl/lvds_pkg.sv
// Shared types and lane-map helpers for the LVDS video packer.
// Word layout is four 7-bit lanes, lane k at bits [7k+6:7k].
package lvds_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 7;
  localparam int WORD_W = LANES * LANE_W;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic first;
  } vtg_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [23:0] rgb,
    input logic        hs,
    input logic        vs,
    input logic        de,
    input logic        jeida
  );
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = rgb[23:16];
    g = rgb[15:8];
    b = rgb[7:0];
    // JEIDA moves the MSBs into the VESA low-bit slots
    if (jeida) begin
      r = {r[1:0], r[7:2]};
      g = {g[1:0], g[7:2]};
      b = {b[1:0], b[7:2]};
    end
    return {1'b0, b[7:6], g[7:6], r[7:6],
            de, vs, hs, b[5:2],
            b[1:0], g[5:1],
            g[0], r[5:0]};
  endfunction

  function automatic logic [WORD_W-1:0] idle_word(
    input logic hs_pol,
    input logic vs_pol
  );
    return pack_word(24'h0, ~hs_pol, ~vs_pol, 1'b0, 1'b0);
  endfunction

endpackage

// File: rtl/lvds_vtg.sv
// Video timing generator: h/v counters with active, FP, sync, BP order.
// Sync outputs are active-high; polarity is applied by the packer.
module lvds_vtg
  import lvds_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output vtg_t tim
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT + 1);
  localparam int VW = $clog2(VT + 1);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [HW-1:0] H_DE   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_DE   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    tim       = '0;
    tim.de    = (h < H_DE) && (v < V_DE);
    tim.hs    = (h >= H_SS) && (h < H_SE);
    tim.vs    = (v >= V_SS) && (v < V_SE);
    tim.first = (h == '0) && (v == '0);
  end

endmodule

// File: rtl/lvds_video_packer.sv
// RGB stream to 28-bit 7:1 LVDS parallel word with internal timing.
// One cycle of latency from counter state to dat_out.
module lvds_video_packer
  import lvds_pkg::*;
#(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int MAP_JEIDA = 0
) (
  input  logic        clkdiv,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic [27:0] dat_out,
  output logic        frame_start,
  output logic        underflow,
  output logic        sof_err,
  input  logic        clr_err
);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);
  localparam logic JEIDA  = (MAP_JEIDA != 0);
  localparam logic [WORD_W-1:0] IDLE = idle_word(HS_ACT, VS_ACT);

  vtg_t        tim;
  logic        run;
  logic        take;
  logic        starve;
  logic        sof_bad;
  logic        hs_lvl;
  logic        vs_lvl;
  logic [23:0] rgb;

  lvds_vtg #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_vtg (
    .clk (clkdiv),
    .rst (rst),
    .en  (en),
    .tim (tim)
  );

  assign run       = en & rst;
  assign pix_ready = tim.de & run;
  assign take      = pix_ready & pix_valid;
  assign starve    = pix_ready & ~pix_valid;
  assign sof_bad   = take & (pix_sof != tim.first);
  assign rgb       = take ? pix_data : 24'h0;
  assign hs_lvl    = tim.hs ? HS_ACT : ~HS_ACT;
  assign vs_lvl    = tim.vs ? VS_ACT : ~VS_ACT;

  // Error flags: a new event in the same cycle beats clr_err
  always_ff @(posedge clkdiv) begin
    if (!rst) begin
      dat_out     <= IDLE;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      dat_out     <= en ? pack_word(rgb, hs_lvl, vs_lvl, tim.de, JEIDA)
                        : IDLE;
      frame_start <= en & tim.first;
      underflow   <= starve | (underflow & ~clr_err);
      sof_err     <= sof_bad | (sof_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_lvds_video_packer.sv
// Directed bench: small timing (HT=8, VT=5), VESA, JEIDA and
// active-high sync instances driven from one stimulus stream.
module tb_lvds_video_packer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        clr_err;

  logic        ready_a, ready_b, ready_c;
  logic [27:0] dat_a, dat_b, dat_c;
  logic        fs_a, fs_b, fs_c;
  logic        uf_a, uf_b, uf_c;
  logic        se_a, se_b, se_c;

  int n_tests;
  int n_fail;
  int cyc;
  int t_fs0;
  int acc;

  lvds_video_packer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .MAP_JEIDA(0)
  ) dut_a (
    .clkdiv(clk), .rst(rst), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(ready_a), .dat_out(dat_a), .frame_start(fs_a),
    .underflow(uf_a), .sof_err(se_a), .clr_err(clr_err)
  );

  lvds_video_packer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .MAP_JEIDA(1)
  ) dut_b (
    .clkdiv(clk), .rst(rst), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(ready_b), .dat_out(dat_b), .frame_start(fs_b),
    .underflow(uf_b), .sof_err(se_b), .clr_err(clr_err)
  );

  lvds_video_packer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .MAP_JEIDA(0)
  ) dut_c (
    .clkdiv(clk), .rst(rst), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(ready_c), .dat_out(dat_c), .frame_start(fs_c),
    .underflow(uf_c), .sof_err(se_c), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted pixels, sampled mid-cycle when everything is settled
  always @(negedge clk)
    if (ready_a && pix_valid) acc++;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    repeat (3) step();
    n_tests++;
    if (dat_a !== 28'h00C0000) begin
      n_fail++; $display("FAIL rst_dat got=%h exp=%h", dat_a, 28'h00C0000);
    end
    n_tests++;
    if (dat_c !== 28'h0000000) begin
      n_fail++; $display("FAIL rst_dat_pol got=%h exp=%h", dat_c, 28'h0);
    end
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready got=%b exp=0", ready_a);
    end
    n_tests++;
    if (uf_a !== 1'b0 || se_a !== 1'b0 || fs_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags got=%b%b%b exp=000", uf_a, se_a, fs_a);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready got=%b exp=0", ready_a);
    end
    en = 1'b1;
    #1;
    n_tests++;
    if (ready_a !== 1'b1) begin
      n_fail++; $display("FAIL en_ready got=%b exp=1", ready_a);
    end
  endtask

  task automatic test_pixels();
    pix_data = 24'hFF0000; pix_valid = 1'b1; pix_sof = 1'b1;
    step();
    t_fs0 = cyc;
    n_tests++;
    if (dat_a !== 28'h07C003F) begin
      n_fail++; $display("FAIL vesa_red got=%h exp=%h", dat_a, 28'h07C003F);
    end
    n_tests++;
    if (dat_b !== 28'h07C003F) begin
      n_fail++; $display("FAIL jeida_red got=%h exp=%h", dat_b, 28'h07C003F);
    end
    n_tests++;
    if (dat_c !== 28'h070003F) begin
      n_fail++; $display("FAIL pol_red got=%h exp=%h", dat_c, 28'h070003F);
    end
    n_tests++;
    if (fs_a !== 1'b1) begin
      n_fail++; $display("FAIL fs_first got=%b exp=1", fs_a);
    end
    pix_data = 24'h010000; pix_sof = 1'b0;
    step();
    n_tests++;
    if (dat_a !== 28'h01C0001) begin
      n_fail++; $display("FAIL vesa_r0 got=%h exp=%h", dat_a, 28'h01C0001);
    end
    n_tests++;
    if (dat_b !== 28'h03C0000) begin
      n_fail++; $display("FAIL jeida_r0 got=%h exp=%h", dat_b, 28'h03C0000);
    end
    n_tests++;
    if (fs_a !== 1'b0) begin
      n_fail++; $display("FAIL fs_pulse got=%b exp=0", fs_a);
    end
  endtask

  task automatic test_underflow();
    pix_valid = 1'b0;
    step();
    n_tests++;
    if (dat_a !== 28'h01C0000) begin
      n_fail++; $display("FAIL uf_word got=%h exp=%h", dat_a, 28'h01C0000);
    end
    n_tests++;
    if (uf_a !== 1'b1) begin
      n_fail++; $display("FAIL uf_set got=%b exp=1", uf_a);
    end
    n_tests++;
    if (ready_a !== 1'b1) begin
      n_fail++; $display("FAIL uf_ready got=%b exp=1", ready_a);
    end
    pix_valid = 1'b1; pix_data = 24'h000080;
    step();
    n_tests++;
    if (dat_a !== 28'h41C0000) begin
      n_fail++; $display("FAIL vesa_b7 got=%h exp=%h", dat_a, 28'h41C0000);
    end
    n_tests++;
    if (uf_a !== 1'b1) begin
      n_fail++; $display("FAIL uf_hold got=%b exp=1", uf_a);
    end
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++; $display("FAIL blank_ready got=%b exp=0", ready_a);
    end
  endtask

  task automatic test_hsync();
    step();
    n_tests++;
    if (dat_a !== 28'h00C0000 || dat_c !== 28'h0) begin
      n_fail++; $display("FAIL fp_word got=%h/%h exp=00c0000/0000000", dat_a, dat_c);
    end
    step();
    n_tests++;
    if (dat_c !== 28'h0040000) begin
      n_fail++; $display("FAIL hs_hi_h5 got=%h exp=%h", dat_c, 28'h0040000);
    end
    n_tests++;
    if (dat_a !== 28'h0080000) begin
      n_fail++; $display("FAIL hs_lo_h5 got=%h exp=%h", dat_a, 28'h0080000);
    end
    step();
    n_tests++;
    if (dat_c !== 28'h0040000) begin
      n_fail++; $display("FAIL hs_hi_h6 got=%h exp=%h", dat_c, 28'h0040000);
    end
    step();
    n_tests++;
    if (dat_c !== 28'h0) begin
      n_fail++; $display("FAIL bp_h7 got=%h exp=%h", dat_c, 28'h0);
    end
  endtask

  task automatic test_sof();
    pix_sof = 1'b1; pix_data = 24'h123456;
    step();
    n_tests++;
    if (se_a !== 1'b1) begin
      n_fail++; $display("FAIL sof_set got=%b exp=1", se_a);
    end
    clr_err = 1'b1;
    step();
    n_tests++;
    if (se_a !== 1'b1) begin
      n_fail++; $display("FAIL sof_set_wins got=%b exp=1", se_a);
    end
    n_tests++;
    if (uf_a !== 1'b0) begin
      n_fail++; $display("FAIL uf_clr got=%b exp=0", uf_a);
    end
    pix_sof = 1'b0;
    step();
    n_tests++;
    if (se_a !== 1'b0) begin
      n_fail++; $display("FAIL sof_clr got=%b exp=0", se_a);
    end
    clr_err = 1'b0;
    step();
  endtask

  task automatic test_vsync();
    repeat (12) step();
    n_tests++;
    if (dat_c !== 28'h0) begin
      n_fail++; $display("FAIL vs_off_v2 got=%h exp=%h", dat_c, 28'h0);
    end
    step();
    n_tests++;
    if (dat_c !== 28'h0080000 || dat_a !== 28'h0040000) begin
      n_fail++; $display("FAIL vs_on_v3 got=%h/%h exp=0080000/0040000", dat_c, dat_a);
    end
    repeat (5) step();
    n_tests++;
    if (dat_c !== 28'h00C0000 || dat_a !== 28'h0) begin
      n_fail++; $display("FAIL hs_vs_both got=%h/%h exp=00c0000/0000000", dat_c, dat_a);
    end
    n_tests++;
    if (acc !== 7) begin
      n_fail++; $display("FAIL pix_count got=%0d exp=7", acc);
    end
  endtask

  task automatic test_frame();
    repeat (10) step();
    n_tests++;
    if (fs_a !== 1'b0) begin
      n_fail++; $display("FAIL fs_early got=%b exp=0", fs_a);
    end
    pix_sof = 1'b0; pix_valid = 1'b1;
    step();
    n_tests++;
    if (fs_a !== 1'b1 || (cyc - t_fs0) !== 40) begin
      n_fail++; $display("FAIL fs_period got=%b/%0d exp=1/40", fs_a, cyc - t_fs0);
    end
    n_tests++;
    if (se_a !== 1'b1) begin
      n_fail++; $display("FAIL sof_missing got=%b exp=1", se_a);
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    #1;
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++; $display("FAIL en0_ready got=%b exp=0", ready_a);
    end
    step();
    n_tests++;
    if (dat_a !== 28'h00C0000 || fs_a !== 1'b0) begin
      n_fail++; $display("FAIL en0_idle got=%h/%b exp=00c0000/0", dat_a, fs_a);
    end
    n_tests++;
    if (se_a !== 1'b1) begin
      n_fail++; $display("FAIL en0_keeps_flag got=%b exp=1", se_a);
    end
    en = 1'b1; pix_sof = 1'b1; pix_data = 24'hFF0000;
    #1;
    n_tests++;
    if (ready_a !== 1'b1) begin
      n_fail++; $display("FAIL en1_ready got=%b exp=1", ready_a);
    end
    step();
    n_tests++;
    if (fs_a !== 1'b1 || dat_a !== 28'h07C003F) begin
      n_fail++; $display("FAIL en1_restart got=%b/%h exp=1/07c003f", fs_a, dat_a);
    end
  endtask

  task automatic test_reset_flags();
    rst = 1'b0; pix_valid = 1'b0;
    step();
    n_tests++;
    if (se_a !== 1'b0 || dat_a !== 28'h00C0000) begin
      n_fail++; $display("FAIL rst_clears got=%b/%h exp=0/00c0000", se_a, dat_a);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; t_fs0 = 0; acc = 0;
    rst = 1'b0; en = 1'b0; clr_err = 1'b0;
    pix_data = 24'h0; pix_valid = 1'b0; pix_sof = 1'b0;
    test_reset();
    test_pixels();
    test_underflow();
    test_hsync();
    test_sof();
    test_vsync();
    test_frame();
    test_en_drop();
    test_reset_flags();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
